// File: rtl/aux_period_meter_pkg.sv
// Shared definitions for the period meter.
//   - meter_state_t : IDLE/RUN encodings of the measurement state machine
//   - ClkFreqHz     : system clock frequency used to turn milliseconds into cycles
//   - cnt_millisec  : number of clk cycles in a given number of milliseconds
package aux_period_meter_pkg;

  localparam int unsigned ClkFreqHz = 100_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } meter_state_t;

  function automatic int unsigned cnt_millisec(input int unsigned ms);
    return ms * (ClkFreqHz / 1000);
  endfunction

endpackage

// File: rtl/aux_period_meter_if.sv
// Result channel of the period meter: one measured period per transfer.
//   period_out  CntBit  measured period in clk cycles (master -> slave)
//   period_vld  1       period_out holds an unconsumed result (master -> slave)
//   period_rdy  1       consumer accepts the result (slave -> master)
interface aux_period_meter_if #(
  parameter int CntBit = 32
);

  logic [CntBit-1:0] period_out;
  logic              period_vld;
  logic              period_rdy;

  modport master (
    output period_out,
    output period_vld,
    input  period_rdy
  );

  modport slave (
    input  period_out,
    input  period_vld,
    output period_rdy
  );

endinterface

// File: rtl/aux_period_meter_edge_detect.sv
// Rising-edge detector for a slow input, reusable by the debouncer.
// Build option: AUX_PERIOD_METER_SYNC_EN adds a 2-flop synchronizer in front
// of the sample register, for inputs that are asynchronous to clk.
//   clk     in   system clock
//   rst     in   synchronous, active-high reset (clears all history)
//   sig_in  in   signal to watch
//   rise    out  high for one cycle after a 0->1 transition of the sampled signal
//                (combinational from registers; the caller registers it if needed)
module aux_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic s_d;
  logic s;
  logic prev;

`ifdef AUX_PERIOD_METER_SYNC_EN
  logic [1:0] sync;

  // Two flops in series give a metastable first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], sig_in};
    end
  end

  assign s_d = sync[1];
`else
  assign s_d = sig_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= 1'b0;
      prev <= 1'b0;
    end else begin
      s    <= s_d;
      prev <= s;
    end
  end

  assign rise = s & ~prev;

endmodule

// File: rtl/aux_period_meter.sv
// Period meter: counts clk cycles between consecutive rising edges of sig_in
// and hands each count out over a valid/ready channel.
// Build option: AUX_PERIOD_METER_SYNC_EN (see aux_edge_detect) only changes
// latency; measured values are identical in both builds.
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   sig_in      in   signal under measurement
//   edge_out    out  1-cycle pulse per detected rising edge
//   overrun     out  sticky: a result was overwritten before being accepted
//   timeout     out  no rising edge for TimeoutMax cycles while measuring
//   result      if   master side of period_out / period_vld / period_rdy
module aux_period_meter
  import aux_period_meter_pkg::*;
#(
  parameter int          CntBit     = 32,
  parameter int unsigned TimeoutMax = cnt_millisec(2000)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sig_in,
  output logic                       edge_out,
  output logic                       overrun,
  output logic                       timeout,
  aux_period_meter_if.master         result
);

  localparam logic [CntBit-1:0] TimeoutCnt = CntBit'(TimeoutMax);
  localparam logic [CntBit-1:0] CntOne     = CntBit'(1);

  meter_state_t      state;
  logic [CntBit-1:0] counter;
  logic [CntBit-1:0] period_q;
  logic              vld_q;
  logic              rise;

  aux_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise)
  );

  assign result.period_out = period_q;
  assign result.period_vld = vld_q;

  // The counter is loaded with 1 on the edge that starts a period, so the
  // value it holds when the next edge arrives equals the period exactly.
  // A pending result is dropped on accept, but a simultaneous new result
  // takes priority and keeps vld high without counting as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      edge_out <= 1'b0;
    end else begin
      edge_out <= rise;

      if (vld_q && result.period_rdy) begin
        vld_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          counter <= '0;
          if (rise) begin
            state   <= RUN;
            counter <= CntOne;
            timeout <= 1'b0;
          end
        end
        RUN: begin
          counter <= (counter == '1) ? counter : counter + CntOne;
          if (rise) begin
            period_q <= counter;
            vld_q    <= 1'b1;
            counter  <= CntOne;
            if (vld_q && !result.period_rdy) begin
              overrun <= 1'b1;
            end
          end else if (counter == TimeoutCnt) begin
            state   <= IDLE;
            counter <= '0;
            timeout <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aux_period_meter.sv
// Directed bench for aux_period_meter (CntBit=16, TimeoutMax=100).
// Works in both builds; edge latency is taken from AUX_PERIOD_METER_SYNC_EN.
module tb_aux_period_meter;

  localparam int CntBit     = 16;
  localparam int TimeoutMax = 100;
`ifdef AUX_PERIOD_METER_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sig_in;
  logic edge_out;
  logic overrun;
  logic timeout;

  aux_period_meter_if #(.CntBit(CntBit)) res_if ();

  aux_period_meter #(
    .CntBit     (CntBit),
    .TimeoutMax (TimeoutMax)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .edge_out (edge_out),
    .overrun  (overrun),
    .timeout  (timeout),
    .result   (res_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Snapshots taken by do_period around the cycle where its rise takes effect
  logic        cap_edge_early, cap_edge, cap_edge_after;
  logic        cap_vld, cap_vld_after, cap_ovr, cap_to_early, cap_to;
  logic [31:0] cap_period;

  typedef struct {
    int   p;
    int   h;
    int   mode;
    int   n;
    int   exp_period;
    logic exp_vld;
    logic exp_ovr;
    logic exp_to_early;
    logic exp_to;
    logic exp_vld_after;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    sig_in            = s;
    res_if.period_rdy = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, " edge_out"},   32'(edge_out), 32'd0);
    checkOutput({tag, " period_out"}, 32'(res_if.period_out), 32'd0);
    checkOutput({tag, " period_vld"}, 32'(res_if.period_vld), 32'd0);
    checkOutput({tag, " overrun"},    32'(overrun), 32'd0);
    checkOutput({tag, " timeout"},    32'(timeout), 32'd0);
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");
  endtask

  // One period of p cycles starting with a rise, high for h cycles.
  // mode: 0 = rdy low, 1 = rdy high, 2 = rdy pulsed only in the cycle the rise lands.
  task automatic do_period(input int p, input int h, input int mode);
    for (int i = 1; i <= p; i++) begin
      applyStimulus(i <= h, (mode == 1) || (mode == 2 && i == Lat + 1));
      tick();
      if (i == Lat) begin
        cap_edge_early = edge_out;
        cap_to_early   = timeout;
      end
      if (i == Lat + 1) begin
        cap_edge   = edge_out;
        cap_period = 32'(res_if.period_out);
        cap_vld    = res_if.period_vld;
        cap_ovr    = overrun;
        cap_to     = timeout;
      end
      if (i == Lat + 2) begin
        cap_edge_after = edge_out;
        cap_vld_after  = res_if.period_vld;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);

    //             p    h  mode n  period vld ovr toE to vldAfter
    vecs[0] = '{ 10,  5, 1, 3,  10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{ 10,  5, 0, 3,  10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{ 10,  5, 0, 2,  10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{ 10,  5, 2, 3,  10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{  4,  2, 1, 3,   4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{  7,  3, 1, 2,   7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{ 13,  1, 1, 4,  13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{ 10,  5, 1, 1,   0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{100, 50, 1, 2, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{101, 50, 1, 2,   0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].n; k++) begin
        do_period(vecs[v].p, vecs[v].h, vecs[v].mode);
      end
      checkOutput($sformatf("v%0d edge_early", v), 32'(cap_edge_early), 32'd0);
      checkOutput($sformatf("v%0d edge", v),       32'(cap_edge), 32'd1);
      checkOutput($sformatf("v%0d period", v),     cap_period, 32'(vecs[v].exp_period));
      checkOutput($sformatf("v%0d vld", v),        32'(cap_vld), 32'(vecs[v].exp_vld));
      checkOutput($sformatf("v%0d overrun", v),    32'(cap_ovr), 32'(vecs[v].exp_ovr));
      checkOutput($sformatf("v%0d to_early", v),   32'(cap_to_early), 32'(vecs[v].exp_to_early));
      checkOutput($sformatf("v%0d timeout", v),    32'(cap_to), 32'(vecs[v].exp_to));
      if (Lat + 2 <= vecs[v].p) begin
        checkOutput($sformatf("v%0d edge_after", v), 32'(cap_edge_after), 32'd0);
        checkOutput($sformatf("v%0d vld_after", v),  32'(cap_vld_after), 32'(vecs[v].exp_vld_after));
      end
    end

    // Held result stays stable, accept drops vld next cycle, overrun is sticky
    do_reset();
    for (int k = 0; k < 3; k++) do_period(10, 5, 0);
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    checkOutput("hold period", 32'(res_if.period_out), 32'd10);
    checkOutput("hold vld",    32'(res_if.period_vld), 32'd1);
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("accept vld",     32'(res_if.period_vld), 32'd0);
    checkOutput("accept overrun", 32'(overrun), 32'd1);
    tick();
    checkOutput("sticky overrun", 32'(overrun), 32'd1);

    // Stalled input: timeout exactly 100 cycles after the arming rise
    do_reset();
    do_period(10, 5, 1);
    applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < Lat + 90; k++) tick();
    checkOutput("timeout before", 32'(timeout), 32'd0);
    tick();
    checkOutput("timeout at 100", 32'(timeout), 32'd1);
    checkOutput("timeout vld",    32'(res_if.period_vld), 32'd0);
    for (int k = 0; k < 20; k++) tick();
    checkOutput("timeout level", 32'(timeout), 32'd1);
    do_period(7, 3, 1);
    checkOutput("rearm to_early", 32'(cap_to_early), 32'd1);
    checkOutput("rearm timeout",  32'(cap_to), 32'd0);
    checkOutput("rearm vld",      32'(cap_vld), 32'd0);
    do_period(7, 3, 1);
    checkOutput("rearm period", cap_period, 32'd7);
    checkOutput("rearm vld2",   32'(cap_vld), 32'd1);

    // Reset in the middle of a measurement discards everything
    do_reset();
    for (int k = 0; k < 3; k++) do_period(10, 5, 0);
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    tick();
    rst = 1'b0;
    check_reset_state("midreset");
    do_period(20, 10, 1);
    checkOutput("midreset arm vld", 32'(cap_vld), 32'd0);
    do_period(20, 10, 1);
    checkOutput("midreset period", cap_period, 32'd20);
    checkOutput("midreset vld",    32'(cap_vld), 32'd1);
    checkOutput("midreset ovr",    32'(cap_ovr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
